// File: rtl/urf_pkg.sv
// Shared types for the universal register file access controller: FSM state
// encoding and the default-width command record.
package urf_pkg;
  localparam int URF_DATA_WIDTH = 8;
  localparam int URF_ADDR_WIDTH = 16;
  localparam int URF_TAG_WIDTH  = 4;

  typedef enum logic [1:0] {
    URF_IDLE    = 2'd0,
    URF_ISSUE   = 2'd1,
    URF_CAPTURE = 2'd2,
    URF_RESP    = 2'd3
  } urf_ctrl_state_e;

  typedef struct packed {
    logic                      write;
    logic [URF_ADDR_WIDTH-1:0] addr;
    logic [URF_DATA_WIDTH-1:0] wdata;
    logic [URF_TAG_WIDTH-1:0]  tag;
  } urf_cmd_t;
endpackage

// File: rtl/urf_cmd_fifo.sv
// In-order command buffer. No bypass: an entry pushed at one edge becomes
// visible at the head only after that edge. A push into a full FIFO is dropped.
module urf_cmd_fifo
  import urf_pkg::*;
#(
  parameter type cmd_t = urf_cmd_t,
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cmd_t                     push_data,
  input  logic                     pop,
  output cmd_t                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/urf_access_ctrl.sv
// Request-side controller for universal_reg_array: buffers read/write commands,
// issues one array operation per slot and returns tagged read responses.
module urf_access_ctrl
  import urf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  arr_write_en,
  output logic                  arr_read_en,
  output logic [ADDR_WIDTH-1:0] arr_write_addr,
  output logic [ADDR_WIDTH-1:0] arr_read_addr,
  output logic [DATA_WIDTH-1:0] arr_write_data,
  input  logic [DATA_WIDTH-1:0] arr_read_data,
  output logic                  idle
);
  localparam logic [1:0] S_IDLE    = 2'(URF_IDLE);
  localparam logic [1:0] S_ISSUE   = 2'(URF_ISSUE);
  localparam logic [1:0] S_CAPTURE = 2'(URF_CAPTURE);
  localparam logic [1:0] S_RESP    = 2'(URF_RESP);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [TAG_WIDTH-1:0]  tag;
  } cmd_t;

  cmd_t                         push_cmd, head;
  logic                         fifo_full, fifo_empty, pop;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic [1:0]                   state;
  logic                         cur_write;
  logic [TAG_WIDTH-1:0]         cur_tag;

  assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, tag: cmd_tag};

  urf_cmd_fifo #(.cmd_t(cmd_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cmd_ready = !fifo_full;
  assign idle      = (fifo_count == '0) && (state == S_IDLE) && !arr_write_en && !arr_read_en;

  // Issue slots: from IDLE, back-to-back behind a write, or on the response handshake.
  always_comb begin
    pop = 1'b0;
    case (state)
      S_IDLE:  pop = !fifo_empty;
      S_ISSUE: pop = cur_write && !fifo_empty;
      S_RESP:  pop = rsp_valid && rsp_ready && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      arr_write_en   <= 1'b0;
      arr_read_en    <= 1'b0;
      arr_write_addr <= '0;
      arr_read_addr  <= '0;
      arr_write_data <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_tag        <= '0;
      cur_write      <= 1'b0;
      cur_tag        <= '0;
    end else begin
      arr_write_en <= 1'b0;
      arr_read_en  <= 1'b0;
      // Address/data registers keep their last value while their enable is low.
      if (pop) begin
        cur_write <= head.write;
        cur_tag   <= head.tag;
        if (head.write) begin
          arr_write_en   <= 1'b1;
          arr_write_addr <= head.addr;
          arr_write_data <= head.wdata;
        end else begin
          arr_read_en    <= 1'b1;
          arr_read_addr  <= head.addr;
        end
      end
      case (state)
        S_IDLE:    if (pop) state <= S_ISSUE;
        S_ISSUE: begin
          // The array registers read_data at the edge leaving ISSUE.
          if (!cur_write) state <= S_CAPTURE;
          else if (!pop)  state <= S_IDLE;
        end
        S_CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_data  <= arr_read_data;
          rsp_tag   <= cur_tag;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= pop ? S_ISSUE : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_urf_access_ctrl.sv
// Directed and randomized checks of urf_access_ctrl against a small array
// model and an in-order reference memory / expected-response queue.
module tb_urf_access_ctrl;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [TW-1:0] cmd_tag;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          arr_write_en, arr_read_en;
  logic [AW-1:0] arr_write_addr, arr_read_addr;
  logic [DW-1:0] arr_write_data, arr_read_data;
  logic          idle;

  always #5 clk = ~clk;

  urf_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .arr_write_en(arr_write_en), .arr_read_en(arr_read_en),
    .arr_write_addr(arr_write_addr), .arr_read_addr(arr_read_addr),
    .arr_write_data(arr_write_data), .arr_read_data(arr_read_data),
    .idle(idle)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_rsp = 0;
  logic rand_rdy = 1'b0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] amem    [16];
  logic [DW-1:0] ref_mem [16];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Array model: registered read data, cleared together with the reference on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) amem[i] <= '0;
      arr_read_data <= '0;
    end else begin
      if (arr_write_en) amem[arr_write_addr[3:0]] <= arr_write_data;
      if (arr_read_en)  arr_read_data <= amem[arr_read_addr[3:0]];
    end
  end

  logic          hold_q = 1'b0;
  logic [DW-1:0] hold_data;
  logic [TW-1:0] hold_tag;
  exp_t          e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_q = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    end else begin
      chk("en_exclusive", 32'(arr_write_en && arr_read_en), 32'd0);
      if (hold_q) begin
        chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_hold_data", 32'(rsp_data), 32'(hold_data));
        chk("rsp_hold_tag", 32'(rsp_tag), 32'(hold_tag));
      end
      hold_q    = rsp_valid && !rsp_ready;
      hold_data = rsp_data;
      hold_tag  = rsp_tag;
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        chk("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_write) ref_mem[cmd_addr[3:0]] = cmd_wdata;
        else exp_q.push_back('{data: ref_mem[cmd_addr[3:0]], tag: cmd_tag});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [TW-1:0] t);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_tag = t;
  endtask

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [TW-1:0] t);
    int n = 0;
    drive(w, a, d, t);
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    while (!cmd_ready && n < 100) begin
      step();
      n++;
      if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    end
    if (!cmd_ready) chk("send_timeout", 32'(cmd_ready), 32'd1);
    step();
  endtask

  task automatic drain();
    int n = 0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    while (!(idle && exp_q.size() == 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_idle", 32'(idle), 32'd1);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_tag = '0; rsp_ready = 1'b1;

    // 1: reset state, then reset with a command offered
    step(); step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_wr_en", 32'(arr_write_en), 32'd0);
    chk("rst_rd_en", 32'(arr_read_en), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_idle", 32'(idle), 32'd1);
    rst = 1'b1;
    drive(1'b1, 16'd5, 8'hEE, 4'd0);
    step(); step();
    rst = 1'b0; cmd_valid = 1'b0;
    step(); step();
    chk("rst_push_wr_en", 32'(arr_write_en), 32'd0);
    chk("rst_push_idle", 32'(idle), 32'd1);

    // 2: write then read of the same address
    n0 = n_rsp;
    drive(1'b1, 16'd3, 8'hA5, 4'd0); step();
    drive(1'b0, 16'd3, 8'h00, 4'd2); step();
    chk("t2_wr_en", 32'(arr_write_en), 32'd1);
    chk("t2_wr_addr", 32'(arr_write_addr), 32'd3);
    chk("t2_wr_data", 32'(arr_write_data), 32'hA5);
    chk("t2_rd_en_lo", 32'(arr_read_en), 32'd0);
    cmd_valid = 1'b0; step();
    chk("t2_rd_en", 32'(arr_read_en), 32'd1);
    chk("t2_rd_addr", 32'(arr_read_addr), 32'd3);
    chk("t2_wr_en_lo", 32'(arr_write_en), 32'd0);
    step();
    chk("t2_rd_en_drop", 32'(arr_read_en), 32'd0);
    chk("t2_rsp_early", 32'(rsp_valid), 32'd0);
    step();
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2_rsp_data", 32'(rsp_data), 32'hA5);
    chk("t2_rsp_tag", 32'(rsp_tag), 32'd2);
    step();
    chk("t2_rsp_done", 32'(rsp_valid), 32'd0);
    chk("t2_idle", 32'(idle), 32'd1);
    chk("t2_rsp_count", 32'(n_rsp - n0), 32'd1);

    // 3: four back-to-back writes
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, 16'(i), 8'(8'h10 + i), 4'd0);
      else cmd_valid = 1'b0;
      step();
      if (i >= 1 && i <= 4) begin
        chk("t3_wr_en", 32'(arr_write_en), 32'd1);
        chk("t3_wr_addr", 32'(arr_write_addr), 32'(i - 1));
        chk("t3_wr_data", 32'(arr_write_data), 32'(8'h10 + i - 1));
      end
    end
    chk("t3_wr_en_drop", 32'(arr_write_en), 32'd0);
    chk("t3_idle", 32'(idle), 32'd1);

    // 4: back-pressure fills the FIFO, sixth read refused
    rsp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 16'(i - 1), 8'h00, 4'(i));
      step();
    end
    chk("t4_full", 32'(cmd_ready), 32'd0);
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t4_rsp_tag", 32'(rsp_tag), 32'd1);
    chk("t4_rsp_data", 32'(rsp_data), 32'h10);
    drive(1'b0, 16'd5, 8'h00, 4'd6);
    step(); step();
    chk("t4_refused", 32'(cmd_ready), 32'd0);
    chk("t4_rsp_tag_hold", 32'(rsp_tag), 32'd1);
    n0 = n_rsp;
    drain();
    chk("t4_rsp_count", 32'(n_rsp - n0), 32'd5);

    // 5: reset while capturing with two reads still queued
    n0 = n_rsp;
    rsp_ready = 1'b1;
    drive(1'b0, 16'd0, 8'h00, 4'd7); step();
    drive(1'b0, 16'd1, 8'h00, 4'd8); step();
    drive(1'b0, 16'd2, 8'h00, 4'd9); step();
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_idle", 32'(idle), 32'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t5_rd_en", 32'(arr_read_en), 32'd0);
    end
    chk("t5_idle", 32'(idle), 32'd1);
    chk("t5_no_rsp", 32'(n_rsp - n0), 32'd0);

    // 6: random mix against the reference model
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 8'($urandom), 4'($urandom));
    end
    rand_rdy = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/urf_access_ctrl.md
Name: urf_access_ctrl

Overview:
- Request-side controller sitting directly upstream of universal_reg_array.
- Accepts read/write commands over a valid/ready interface and buffers them in order in a small command FIFO.
- Drives the array's write_en/read_en/address/data pins, one operation per issue slot, never both enables at once.
- Captures the array's registered read_data and returns it as a tagged response over a valid/ready interface.

Parameters:
- DATA_WIDTH, 8: data width; matches the array.
- ADDR_WIDTH, 16: array address port width; matches the array's address ports.
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥2.
- TAG_WIDTH, 4: width of the command tag echoed on the response.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- cmd_tag  in  TAG_WIDTH  read tag (ignored for writes)
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_WIDTH  read data
- rsp_tag  out  TAG_WIDTH  tag of the originating read
- arr_write_en  out  1  to array write_en
- arr_read_en  out  1  to array read_en
- arr_write_addr  out  ADDR_WIDTH  to array write_addr
- arr_read_addr  out  ADDR_WIDTH  to array read_addr
- arr_write_data  out  DATA_WIDTH  to array write_data
- arr_read_data  in  DATA_WIDTH  from array read_data
- idle  out  1  no work pending or in flight

Behaviour:
- One clock domain: clk. rst is asynchronous, active-high.
- Reset: all outputs 0 except cmd_ready=1 and idle=1. FIFO is flushed, state=IDLE.
- Reset mid-operation: in-flight reads and the pending response are discarded; no response is produced after reset.
- All outputs are registered. cmd_ready = !full, derived from registered occupancy.
- Push occurs on cmd_valid&&cmd_ready. There is no FIFO bypass: a command pushed at edge E0 is poppable no earlier than E1.
- Full FIFO: cmd_ready=0 and pushes are refused, even if a pop occurs in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is clog2(FIFO_DEPTH)+1 bits.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE, FIFO non-empty: pop head at edge. Write → arr_write_en=1; read → arr_read_en=1. Address/data registered; next state ISSUE.
- ISSUE of a write, FIFO non-empty: pop the next head and issue it as in IDLE. This gives writes 1/cycle throughput, and a read following a write issues the next cycle.
- ISSUE of a write, FIFO empty: enables drop to 0; next state IDLE.
- ISSUE of a read: enables drop to 0, no pop; next state CAPTURE (array latches read_data at this edge).
- CAPTURE: rsp_data<=arr_read_data, rsp_tag<=stored tag, rsp_valid<=1; next state RESP.
- RESP: hold rsp_* stable while !rsp_ready. On rsp_valid&&rsp_ready, rsp_valid<=0. If FIFO non-empty, pop/issue on the same edge (→ISSUE), else →IDLE.
- Only one read is outstanding at a time.
- Read latency: accept at E0 → arr_read_en high after E1 → rsp_valid high after E3.
- Write latency: arr_write_en high after E1; array updated at E2.
- Ordering: strictly in command order. A read after a write to the same address returns the new data.
- arr_write_en and arr_read_en are never high in the same cycle. Disabled address/data outputs hold their last value.
- Addresses pass through unchanged; no range check is performed (array's responsibility).
- Array busy output is not consumed.
- Writes generate no response.
- idle = FIFO empty && state==IDLE && !arr_write_en && !arr_read_en.

Decomposition:
- Package urf_pkg:
  - state enum typedef urf_ctrl_state_e.
  - packed struct urf_cmd_t {write, addr, wdata, tag}, parameterised via localparams mirroring the defaults.
- Sub-module urf_cmd_fifo:
  - synchronous FIFO of urf_cmd_t with push/pop/full/empty/count.
  - same clk/rst convention.

Test Plan:
1. Reset assert/deassert → cmd_ready=1, idle=1, rsp_valid=0, both arr enables 0; repeat reset while cmd_valid=1 → no push.
2. Write 0xA5 @3, then read @3 tag 0x2 on consecutive cycles, rsp_ready=1 → arr_write_en high one cycle, arr_read_en high the next cycle; rsp_valid with rsp_data=0xA5, rsp_tag=0x2, 3 cycles after the read's accept edge.
3. Four back-to-back writes (addr 0..3, data 0x10..0x13) → arr_write_en high 4 consecutive cycles with matching addr/data; idle returns to 1.
4. rsp_ready=0, push reads tags 1..6 → first read parks in RESP, 4 entries fill the FIFO, cmd_ready=0, tag 6 refused; then rsp_ready=1 → responses arrive with tags 1,2,3,4,5 in order.
5. Assert rst while in CAPTURE with FIFO holding 2 entries → rsp_valid stays 0, idle=1, no further arr enables after release.
6. Random mix, 1000 commands, checked against a reference memory model → data/tag match in order; assertion that arr_write_en&&arr_read_en is never true; rsp_* stable while rsp_valid&&!rsp_ready.
